// File: rtl/temp_conversion_stream_if.sv
// Sample/result stream bundle for temp_conversion_stream.
// The master modport is the producer/consumer side. The converter uses the slave modport.
interface temp_conversion_stream_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  temperature;
   logic             unit;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] data;
   logic             out_unit;
   logic             err;

   modport master (
      output in_valid, temperature, unit, out_ready,
      input  in_ready, out_valid, data, out_unit, err
   );

   modport slave (
      input  in_valid, temperature, unit, out_ready,
      output in_ready, out_valid, data, out_unit, err
   );
endinterface

// File: rtl/temp_conversion_stream.sv
// Two-stage streaming Celsius/Fahrenheit converter with valid/ready backpressure,
// range/saturation error flagging and saturating conversion/error counters.
module temp_conversion_stream #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8,
   parameter int C_MAX = 100,
   parameter int F_MIN = 32,
   parameter int F_MAX = 212,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   temp_conversion_stream_if.slave bus,
   input  logic                   clear_counts,
   output logic [CNT_W-1:0]       conv_count,
   output logic [CNT_W-1:0]       err_count
);

   // 18*C+5 and 10*(F-32)+9 both stay below 2^(IN_W+5)
   localparam int NUM_W = IN_W + 6;
   localparam int EXT_W = IN_W + 32;
   localparam int CMP_W = NUM_W + OUT_W;
   localparam logic [CMP_W-1:0] OUT_MAX = {{NUM_W{1'b0}}, {OUT_W{1'b1}}};

   logic             adv;
   logic             s1_valid, s1_unit, s1_err;
   logic [NUM_W-1:0] s1_num;
   logic             out_valid_q, out_unit_q, err_q;
   logic [OUT_W-1:0] data_q;

   logic [EXT_W-1:0] t_ext;
   logic             in_err;
   logic [NUM_W-1:0] in_num;
   logic [NUM_W-1:0] quo;
   logic [CMP_W-1:0] quo_ext;
   logic [OUT_W-1:0] res_data;
   logic             res_err;
   logic             in_xfer, err_xfer;

   assign adv          = !out_valid_q || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = out_valid_q;
   assign bus.data      = data_q;
   assign bus.out_unit  = out_unit_q;
   assign bus.err       = err_q;

   assign t_ext = EXT_W'(bus.temperature);

   always_comb begin
      in_err = 1'b0;
      in_num = '0;
      if (bus.unit) begin
         in_err = t_ext > EXT_W'(C_MAX);
         in_num = NUM_W'(bus.temperature) * NUM_W'(18) + NUM_W'(5);
      end else begin
         in_err = (t_ext < EXT_W'(F_MIN)) || (t_ext > EXT_W'(F_MAX));
         in_num = NUM_W'(bus.temperature - IN_W'(F_MIN)) * NUM_W'(10) + NUM_W'(9);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_unit  <= 1'b0;
         s1_err   <= 1'b0;
         s1_num   <= '0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         s1_unit  <= bus.unit;
         s1_err   <= in_err;
         s1_num   <= in_num;
      end
   end

   always_comb begin
      if (s1_unit) quo = s1_num / NUM_W'(10) + NUM_W'(F_MIN);
      else         quo = s1_num / NUM_W'(18);
      quo_ext  = CMP_W'(quo);
      res_err  = 1'b0;
      res_data = quo_ext[OUT_W-1:0];
      if (s1_err) begin
         res_err  = 1'b1;
         res_data = '0;
      end else if (quo_ext > OUT_MAX) begin
         res_err  = 1'b1;
         res_data = '1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         out_unit_q  <= 1'b0;
         err_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s1_valid;
         data_q      <= res_data;
         out_unit_q  <= s1_unit;
         err_q       <= res_err;
      end
   end

   assign in_xfer  = bus.in_valid && adv;
   assign err_xfer = out_valid_q && bus.out_ready && err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conv_count <= '0;
         err_count  <= '0;
      end else if (clear_counts) begin
         conv_count <= '0;
         err_count  <= '0;
      end else begin
         if (in_xfer && (conv_count != '1)) conv_count <= conv_count + CNT_W'(1);
         if (err_xfer && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_temp_conversion_stream.sv
// Scoreboard bench for temp_conversion_stream: an 8-bit instance for the conversion,
// range, backpressure and reset scenarios, and a 6-bit/4-bit-counter instance for saturation.
module tb_temp_conversion_stream;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   temp_conversion_stream_if #(.IN_W(8), .OUT_W(8)) bus ();
   logic        clear_counts;
   logic [15:0] conv_count, err_count;

   temp_conversion_stream #(
      .IN_W(8), .OUT_W(8), .C_MAX(100), .F_MIN(32), .F_MAX(212), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .clear_counts(clear_counts), .conv_count(conv_count), .err_count(err_count)
   );

   temp_conversion_stream_if #(.IN_W(8), .OUT_W(6)) bus6 ();
   logic       clear6;
   logic [3:0] conv6, err6;

   temp_conversion_stream #(
      .IN_W(8), .OUT_W(6), .C_MAX(100), .F_MIN(32), .F_MAX(212), .CNT_W(4)
   ) dut6 (
      .clk(clk), .reset(reset), .bus(bus6),
      .clear_counts(clear6), .conv_count(conv6), .err_count(err6)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       unit;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   logic rand_ready = 1'b0;

   logic       stall_prev = 1'b0;
   logic [7:0] data_prev;
   logic       unit_prev, err_prev;

   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            tests++;
            if (bus.out_valid !== 1'b1 || bus.data !== data_prev ||
                bus.out_unit !== unit_prev || bus.err !== err_prev) begin
               fails++;
               $display("FAIL stall_hold: valid=%b data=%0d unit=%b err=%b, required valid=1 data=%0d unit=%b err=%b",
                        bus.out_valid, bus.data, bus.out_unit, bus.err, data_prev, unit_prev, err_prev);
            end
         end
         if (bus.out_valid && !bus.out_ready) begin
            tests++;
            if (bus.in_ready !== 1'b0) begin
               fails++;
               $display("FAIL stall_in_ready: in_ready=%b, required 0", bus.in_ready);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: data=%0d unit=%b err=%b, required no output",
                        bus.data, bus.out_unit, bus.err);
            end else begin
               mon_e = sb.pop_front();
               if (bus.data !== mon_e.data || bus.out_unit !== mon_e.unit || bus.err !== mon_e.err) begin
                  fails++;
                  $display("FAIL output: data=%0d unit=%b err=%b, required data=%0d unit=%b err=%b",
                           bus.data, bus.out_unit, bus.err, mon_e.data, mon_e.unit, mon_e.err);
               end
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         data_prev  = bus.data;
         unit_prev  = bus.out_unit;
         err_prev   = bus.err;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds in_valid high until accepted; pushes the expected result at acceptance.
   task automatic send(input logic [7:0] t, input logic u, input logic [7:0] ed, input logic ee);
      int   n;
      logic acc;
      bus.in_valid    = 1'b1;
      bus.temperature = t;
      bus.unit        = u;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.in_ready;
         if (acc) sb.push_back({ed, u, ee});
         step();
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: temperature=%0d not accepted, required acceptance within 100 cycles", t);
      end
   endtask

   task automatic drain();
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         step();
         n++;
      end
      step();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      clear_counts    = 1'b0;
      clear6          = 1'b0;
      bus.in_valid    = 1'b0;
      bus.temperature = '0;
      bus.unit        = 1'b0;
      bus.out_ready   = 1'b1;
      bus6.in_valid    = 1'b0;
      bus6.temperature = '0;
      bus6.unit        = 1'b0;
      bus6.out_ready   = 1'b1;
      step();
      step();
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
      tests++;
      if (bus.data !== 8'd0 || bus.out_unit !== 1'b0 || bus.err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: data=%0d unit=%b err=%b, required 0 0 0", bus.data, bus.out_unit, bus.err);
      end
      tests++;
      if (conv_count !== 16'd0 || err_count !== 16'd0) begin
         fails++;
         $display("FAIL reset_counts: conv=%0d err=%0d, required 0 0", conv_count, err_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_c2f();
      logic [7:0] cin [3]  = '{8'd1, 8'd37, 8'd100};
      logic [7:0] fexp [3] = '{8'd34, 8'd99, 8'd212};
      bus.in_valid    = 1'b1;
      bus.temperature = 8'd0;
      bus.unit        = 1'b1;
      sb.push_back({8'd32, 1'b1, 1'b0});
      step();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL latency_early: out_valid=%b after 1 edge, required 0", bus.out_valid);
      end
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.data !== 8'd32) begin
         fails++;
         $display("FAIL latency: out_valid=%b data=%0d after 2 edges, required 1 32", bus.out_valid, bus.data);
      end
      for (int i = 0; i < 3; i++) send(cin[i], 1'b1, fexp[i], 1'b0);
      drain();
      tests++;
      if (conv_count !== 16'd4) begin
         fails++;
         $display("FAIL c2f_conv_count: %0d, required 4", conv_count);
      end
   endtask

   task automatic test_f2c();
      logic [7:0] fin [5]  = '{8'd32, 8'd33, 8'd34, 8'd98, 8'd212};
      logic [7:0] cexp [5] = '{8'd0, 8'd1, 8'd1, 8'd37, 8'd100};
      for (int i = 0; i < 5; i++) send(fin[i], 1'b0, cexp[i], 1'b0);
      drain();
      tests++;
      if (err_count !== 16'd0) begin
         fails++;
         $display("FAIL f2c_err_count: %0d, required 0", err_count);
      end
   endtask

   task automatic test_range_err();
      send(8'd101, 1'b1, 8'd0, 1'b1);
      send(8'd31,  1'b0, 8'd0, 1'b1);
      send(8'd213, 1'b0, 8'd0, 1'b1);
      drain();
      tests++;
      if (err_count !== 16'd3) begin
         fails++;
         $display("FAIL range_err_count: %0d, required 3", err_count);
      end
   endtask

   task automatic test_clear();
      clear_counts    = 1'b1;
      bus.in_valid    = 1'b1;
      bus.temperature = 8'd0;
      bus.unit        = 1'b1;
      sb.push_back({8'd32, 1'b1, 1'b0});
      step();
      clear_counts = 1'b0;
      bus.in_valid = 1'b0;
      tests++;
      if (conv_count !== 16'd0 || err_count !== 16'd0) begin
         fails++;
         $display("FAIL clear_priority: conv=%0d err=%0d, required 0 0", conv_count, err_count);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] fexp [10] = '{8'd32, 8'd34, 8'd36, 8'd37, 8'd39, 8'd41, 8'd43, 8'd45, 8'd46, 8'd48};
      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(8'(i), 1'b1, fexp[i], 1'b0);
      rand_ready = 1'b0;
      drain();
      tests++;
      if (conv_count !== 16'd10) begin
         fails++;
         $display("FAIL backpressure_conv_count: %0d, required 10", conv_count);
      end
   endtask

   task automatic test_saturation();
      bus6.in_valid    = 1'b1;
      bus6.unit        = 1'b1;
      bus6.temperature = 8'd17;
      step();
      bus6.temperature = 8'd20;
      step();
      bus6.in_valid = 1'b0;
      tests++;
      if (bus6.out_valid !== 1'b1 || bus6.data !== 6'd63 || bus6.err !== 1'b0) begin
         fails++;
         $display("FAIL sat_edge: valid=%b data=%0d err=%b, required 1 63 0", bus6.out_valid, bus6.data, bus6.err);
      end
      step();
      tests++;
      if (bus6.out_valid !== 1'b1 || bus6.data !== 6'd63 || bus6.err !== 1'b1 || bus6.out_unit !== 1'b1) begin
         fails++;
         $display("FAIL sat_over: valid=%b data=%0d err=%b unit=%b, required 1 63 1 1",
                  bus6.out_valid, bus6.data, bus6.err, bus6.out_unit);
      end
      bus6.in_valid = 1'b1;
      repeat (17) step();
      bus6.in_valid = 1'b0;
      tests++;
      if (conv6 !== 4'hF) begin
         fails++;
         $display("FAIL conv_count_sat: %0d, required 15", conv6);
      end
      repeat (3) step();
      tests++;
      if (err6 !== 4'hF) begin
         fails++;
         $display("FAIL err_count_sat: %0d, required 15", err6);
      end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready   = 1'b0;
      bus.in_valid    = 1'b1;
      bus.unit        = 1'b1;
      bus.temperature = 8'd50;
      step();
      bus.temperature = 8'd60;
      step();
      bus.in_valid = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL pre_reset_stall: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL async_reset: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
      tests++;
      if (conv_count !== 16'd0 || err_count !== 16'd0 || conv6 !== 4'd0 || err6 !== 4'd0) begin
         fails++;
         $display("FAIL async_reset_counts: conv=%0d err=%0d conv6=%0d err6=%0d, required all 0",
                  conv_count, err_count, conv6, err6);
      end
      step();
      step();
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid    = 1'b1;
      bus.unit        = 1'b0;
      bus.temperature = 8'd212;
      sb.push_back({8'd100, 1'b0, 1'b0});
      step();
      bus.in_valid = 1'b0;
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.data !== 8'd100) begin
         fails++;
         $display("FAIL post_reset_sample: valid=%b data=%0d, required 1 100", bus.out_valid, bus.data);
      end
      drain();
      tests++;
      if (conv_count !== 16'd1) begin
         fails++;
         $display("FAIL post_reset_conv_count: %0d, required 1", conv_count);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_c2f();
      test_f2c();
      test_range_err();
      test_clear();
      test_back_to_back();
      test_saturation();
      test_reset_midstream();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_empty: %0d outstanding, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
